// File: rtl/sum_of_squares.sv
// Sequential x^2+y^2+z^2 for a signed point using three shift-add squarers, one multiplier bit per cycle.
// Result registers W+2 edges after accept, counting the accept edge; out_valid is held until out_ready.
// Only accepts a point in IDLE. Optional SOS_SATURATE_EN clamps an oversized sum to all-ones instead of truncating it.
module sum_of_squares #(
  parameter int W = 16,
  parameter int N = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] z,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        sum_sq
);

  localparam int CW = $clog2(W);
  localparam int SW = 2*W + 2;
  localparam int XW = (N > SW) ? N : SW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ADD, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_mx, r_my, r_mz;
  logic [2*W-1:0]  r_ax, r_ay, r_az;
  logic [N-1:0]    r_sum;
  logic [SW-1:0]   w_s;
  logic [N-1:0]    w_res;

  // Two's-complement magnitude; -2^(W-1) maps to 2^(W-1), which still fits W unsigned bits.
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + W'(1)) : v;
  endfunction

  function automatic logic [2*W-1:0] step(input logic [2*W-1:0] acc,
                                          input logic [W-1:0]   m,
                                          input logic [CW-1:0]  i);
    logic [2*W-1:0] w_m;
    w_m = {{W{1'b0}}, m};
    return m[i] ? (acc + (w_m << i)) : acc;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = reset_n;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN:  if (r_cnt == CW'(W-1)) w_next = S_ADD;
      S_ADD:  w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_s = SW'(r_ax) + SW'(r_ay) + SW'(r_az);

`ifdef SOS_SATURATE_EN
  logic w_ovf;
  assign w_ovf = (XW'(w_s) >> N) != '0;
  assign w_res = w_ovf ? {N{1'b1}} : N'(w_s);
`else
  assign w_res = N'(w_s);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_mx  <= '0;
      r_my  <= '0;
      r_mz  <= '0;
      r_ax  <= '0;
      r_ay  <= '0;
      r_az  <= '0;
      r_sum <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_mx  <= mag(x);
          r_my  <= mag(y);
          r_mz  <= mag(z);
          r_ax  <= '0;
          r_ay  <= '0;
          r_az  <= '0;
          r_cnt <= '0;
        end
        S_RUN: begin
          r_ax  <= step(r_ax, r_mx, r_cnt);
          r_ay  <= step(r_ay, r_my, r_cnt);
          r_az  <= step(r_az, r_mz, r_cnt);
          r_cnt <= r_cnt + CW'(1);
        end
        S_ADD:   r_sum <= w_res;
        default: ;
      endcase
    end
  end

  assign sum_sq = r_sum;

endmodule

// File: tb/tb_sum_of_squares.sv
// Scoreboard bench for sum_of_squares (W=16, N=32), plus an N=24 instance for the width-conversion corner.
module tb_sum_of_squares;
  localparam int W = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                reset_n, in_valid, in_ready, out_valid, out_ready;
  logic signed [W-1:0] x, y, z;
  logic [31:0]         sum_sq;
  logic                v24, rdy24, ov24, r24;
  logic [23:0]         s24;

  sum_of_squares #(.W(W), .N(32)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .out_valid(out_valid), .out_ready(out_ready), .sum_sq(sum_sq));

  sum_of_squares #(.W(W), .N(24)) dut24 (
    .clock(clock), .reset_n(reset_n), .in_valid(v24), .in_ready(rdy24),
    .x(x), .y(y), .z(z), .out_valid(ov24), .out_ready(r24), .sum_sq(s24));

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] exp_q[$];
  int          pushed = 0, popped = 0, viol = 0;
  bit          busy = 0, rnd = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops on every output handshake and tracks in_ready against the bench's busy view.
  always @(negedge clock) begin
    if (!reset_n) begin
      busy = 0;
    end else begin
      if (busy && in_ready) viol++;
      if (in_valid && in_ready) busy = 1;
      else if (out_valid && out_ready) begin
        busy = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %0d expected none", sum_sq);
        end else begin
          popped++;
          chk("result", longint'(sum_sq), longint'(exp_q.pop_front()));
        end
      end
    end
  end

  always @(posedge clock) if (rnd) #1 out_ready = 1'($urandom_range(0, 1));

  task automatic send(input int a, input int b, input int c, input logic [31:0] e,
                      input bit push, input bit keep);
    int t;
    t = 0;
    x = W'(a); y = W'(b); z = W'(c);
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clock);
    if (push) begin
      exp_q.push_back(e);
      pushed++;
    end
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  // Edges counted including the accepting edge.
  task automatic wait_ov(output int edges);
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clock);
      #1;
      edges++;
    end
  endtask

  task automatic drain();
    @(posedge clock);
    #1;
  endtask

  int          tx[10] = '{100, 32767, -1, 0, 7, -32768, 255, 1, -12345, 1000};
  int          ty[10] = '{-200, 32767, -1, 0, -8, 0, -256, 0, 0, 1000};
  int          tz[10] = '{300, 32767, -1, 0, 9, 1, 1000, 0, 0, 1000};
  logic [31:0] te[10] = '{32'd140000, 32'd3221028867, 32'd3, 32'd0, 32'd194,
                          32'd1073741825, 32'd1130561, 32'd1, 32'd152399025, 32'd3000000};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e, hold_bad, t;
    logic [23:0] exp24;
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; z = '0;
    v24 = 1'b0; r24 = 1'b1;
    #1 reset_n = 1'b0;
    #11;
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sum_sq", longint'(sum_sq), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    #1 chk("rel_in_ready", longint'(in_ready), 1);

    send(3, 4, 0, 32'd25, 1, 0);
    wait_ov(e);
    chk("lat_3_4_0", e, 18);
    chk("sum_3_4_0", longint'(sum_sq), 25);
    drain();

    send(-32768, -32768, -32768, 32'hC000_0000, 1, 0);
    wait_ov(e);
    chk("sum_max_neg", longint'(sum_sq), longint'(32'hC000_0000));
    drain();

    out_ready = 1'b0;
    send(-1, 2, -3, 32'd14, 1, 0);
    wait_ov(e);
    hold_bad = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (sum_sq !== 32'd14 || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad++;
    end
    chk("hold_stable", hold_bad, 0);
    out_ready = 1'b1;
    drain();
    chk("post_out_valid", longint'(out_valid), 0);
    chk("post_in_ready", longint'(in_ready), 1);
    chk("sum_kept", longint'(sum_sq), 14);

    send(5, 5, 5, 32'd0, 0, 0);
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_sum_sq", longint'(sum_sq), 0);
    chk("abort_in_ready", longint'(in_ready), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    send(1, 1, 1, 32'd3, 1, 0);
    wait_ov(e);
    chk("lat_after_reset", e, 18);
    drain();

`ifdef SOS_SATURATE_EN
    exp24 = 24'hFF_FFFF;
`else
    exp24 = 24'h00_0000;
`endif
    x = -16'sd32768; y = -16'sd32768; z = -16'sd32768;
    chk("n24_ready", longint'(rdy24), 1);
    v24 = 1'b1;
    @(posedge clock);
    #1 v24 = 1'b0;
    t = 0;
    while (!ov24 && t < 100) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("n24_valid", longint'(ov24), 1);
    chk("n24_sum", longint'(s24), longint'(exp24));
    drain();

    rnd = 1;
    for (int i = 0; i < 10; i++) send(tx[i], ty[i], tz[i], te[i], 1, 1);
    in_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clock);
      t++;
    end
    rnd = 0;
    #2 out_ready = 1'b1;
    repeat (3) @(posedge clock);

    chk("in_ready_violations", viol, 0);
    chk("queue_empty", exp_q.size(), 0);
    chk("result_count", popped, pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
